bp_be_dep_tracker: RTL
======================

// Module: bp_be_dep_tracker
// PURPOSE
// - Producer side of the BE dependency-status interface: records every dispatched instruction and
//   shifts its writeback/serialisation metadata down a pipe_depth_p-stage shadow of the calculator.
// - Drives per-stage dep status (ex1=stage 0 .. last stage) plus summary flags to the hazard detector.
// - Issue/checker stage dispatches into it; the calculator exception/redirect path flushes it.
// PARAMETERS
// - pipe_depth_p     5  tracked stages (0=ex1, 1=ex2, 2=iwb, 3=fwb, 4=retired shadow)
// - reg_addr_width_p 5  architectural register index width
// - flush_depth_p    3  stages 0..flush_depth_p-1 are killed by flush_i
// - mul_lat_p        2  cycles until mul result is forwardable
// - mem_lat_p        3  cycles until load result is forwardable
// - fp_lat_p         4  cycles until FP-pipe result is forwardable
// PORTS
// - clk_i            in   1            clock
// - reset_i          in   1            synchronous, active-high reset
// - dispatch_v_i     in   1            instruction enters stage 0 next cycle
// - rd_addr_i        in   reg_addr_width_p  destination register
// - irf_w_v_i        in   1            writes integer RF
// - frf_w_v_i        in   1            writes FP RF
// - pipe_sel_i       in   2            0=int, 1=mul, 2=mem, 3=fp
// - serial_i         in   1            instruction requires pipeline drain behind it
// - flush_i          in   1            kill stages 0..flush_depth_p-1 and the incoming dispatch
// - v_o              out  pipe_depth_p  stage holds a live instruction
// - rd_addr_o        out  pipe_depth_p*reg_addr_width_p  per-stage rd (stage k at [k*W +: W])
// - mul_iwb_v_o, mem_iwb_v_o, fp_iwb_v_o  out pipe_depth_p  integer result still pending, by class
// - mem_fwb_v_o, fp_fwb_v_o              out pipe_depth_p  FP result still pending, by class
// - mem_v_o          out  pipe_depth_p  stage holds a memory op
// - serial_v_o       out  pipe_depth_p  stage holds a serialising op
// - instr_in_pipe_o  out  1            |v_o[2:0]
// - mem_in_pipe_o    out  1            |mem_v_o[2:0]
// - serial_haz_o     out  1            |serial_v_o[3:0]
// BEHAVIOUR
// - Reset: all stage registers cleared; every output 0 the cycle after reset_i high. Reset dominates.
// - Each cycle stage k+1 <= stage k for all k (no stall; BE pipe is non-blocking after dispatch);
//   stage 0 <= new entry if dispatch_v_i & ~flush_i, else bubble (all fields 0). Last stage drops off.
// - Entry fields latched from inputs: v=1, rd_addr, class, irf/frf write, mem_v=(pipe_sel_i==2), serial.
// - Pending flags are a function of stage index k and class, lat = class latency:
//   *_iwb_v[k] = v & irf_w & class match & (k < lat-1); *_fwb_v[k] same with frf_w.
//   -> mul pending in stage 0 only; mem in stages 0-1; fp in stages 0-2. Int class never pending.
// - irf_w_v_i with rd_addr_i==0 clears all iwb flags for that entry (x0 never a hazard); fwb unaffected.
// - Flags computed combinationally from registered stage state; outputs have no comb path from inputs.
// - flush_i: stages 0..flush_depth_p-1 become bubbles in the same update as the shift, i.e. after the
//   edge stages 1..flush_depth_p-1 are empty (killed contents do not advance); stage flush_depth_p
//   receives the old stage flush_depth_p-1 contents only if flush_depth_p-1 is not killed -> it is
//   killed, so stage flush_depth_p gets a bubble; stages > flush_depth_p shift normally.
// - Simultaneous dispatch_v_i & flush_i: dispatch dropped. Dispatch with irf_w & frf_w both 0: entry
//   still tracked (v, mem_v, serial) with no pending flags.
// - pipe_sel_i, rd_addr_i ignored when dispatch_v_i=0. Reset mid-flight drops all entries.
// - Assertions: irf_w_v_i & frf_w_v_i never both set; lat params satisfy 1<=lat<=pipe_depth_p.
// TESTING
// - Reset then idle 10 cycles -> all outputs 0.
// - Dispatch load rd=5 irf_w at t0 -> t1: v_o=00001, mem_iwb_v_o=00001, mem_in_pipe_o=1;
//   t2: mem_iwb_v_o=00010; t3: mem_iwb_v_o=0, v_o=00100; t6: v_o=0.
// - Dispatch fp op rd=3 frf_w at t0 -> fp_fwb_v_o 00001,00010,00100 on t1..t3, 0 at t4; rd_addr_o stage k=3.
// - Back-to-back mul rd=0, mul rd=7 -> rd=0 entry: mul_iwb_v never set; rd=7 entry: mul_iwb_v_o=00001 at t2.
// - 4 dispatches t0..t3, flush_i with dispatch at t4 -> t5: v_o=10000 (stage0 bubble), serial/instr_in_pipe_o=0.
// - Serial op dispatched t0 -> serial_haz_o=1 on t1..t4, 0 at t5; reset_i at t2 -> serial_haz_o=0 at t3.

Source files
------------

// File: rtl/bp_be_dep_tracker.sv
// bp_be_dep_tracker
//   Producer side of the BE dependency-status interface. Every dispatched
//   instruction is recorded in stage 0 of a pipe_depth_p-stage shadow of the
//   calculator and shifts down one stage per cycle. From the registered stage
//   contents it reports per-stage writeback/serialisation status plus summary
//   flags to the hazard detector.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   dispatch_v_i         instruction enters stage 0 next cycle
//   rd_addr_i            destination register
//   irf_w_v_i/frf_w_v_i  writes integer / FP register file
//   pipe_sel_i           0=int, 1=mul, 2=mem, 3=fp
//   serial_i             instruction requires a pipeline drain behind it
//   flush_i              kill stages 0..flush_depth_p-1 and the incoming dispatch
//   v_o, rd_addr_o       per-stage valid and rd (stage k at [k*W +: W])
//   *_iwb_v_o/*_fwb_v_o  per-stage integer / FP result still pending, by class
//   mem_v_o, serial_v_o  per-stage memory op / serialising op
//   instr_in_pipe_o, mem_in_pipe_o, serial_haz_o  summary flags
module bp_be_dep_tracker #(
   parameter int unsigned pipe_depth_p     = 5,
   parameter int unsigned reg_addr_width_p = 5,
   parameter int unsigned flush_depth_p    = 3,
   parameter int unsigned mul_lat_p        = 2,
   parameter int unsigned mem_lat_p        = 3,
   parameter int unsigned fp_lat_p         = 4
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     dispatch_v_i,
   input  logic [reg_addr_width_p-1:0]              rd_addr_i,
   input  logic                                     irf_w_v_i,
   input  logic                                     frf_w_v_i,
   input  logic [1:0]                               pipe_sel_i,
   input  logic                                     serial_i,
   input  logic                                     flush_i,
   output logic [pipe_depth_p-1:0]                  v_o,
   output logic [pipe_depth_p*reg_addr_width_p-1:0] rd_addr_o,
   output logic [pipe_depth_p-1:0]                  mul_iwb_v_o,
   output logic [pipe_depth_p-1:0]                  mem_iwb_v_o,
   output logic [pipe_depth_p-1:0]                  fp_iwb_v_o,
   output logic [pipe_depth_p-1:0]                  mem_fwb_v_o,
   output logic [pipe_depth_p-1:0]                  fp_fwb_v_o,
   output logic [pipe_depth_p-1:0]                  mem_v_o,
   output logic [pipe_depth_p-1:0]                  serial_v_o,
   output logic                                     instr_in_pipe_o,
   output logic                                     mem_in_pipe_o,
   output logic                                     serial_haz_o
);

   typedef enum logic [1:0] {
      pipe_int = 2'd0,
      pipe_mul = 2'd1,
      pipe_mem = 2'd2,
      pipe_fp  = 2'd3
   } pipe_e;

   typedef struct packed {
      logic                        v;
      logic [reg_addr_width_p-1:0] rd;
      pipe_e                       cls;
      logic                        irf_w;
      logic                        frf_w;
      logic                        serial;
   } entry_s;

   entry_s [pipe_depth_p-1:0] stage_r;
   entry_s [pipe_depth_p-1:0] stage_n;
   entry_s                    dispatch_entry;

   // Parameter sanity, checked at elaboration.
   if (pipe_depth_p < 4 || flush_depth_p >= pipe_depth_p) begin : g_bad_depth
      $error("bp_be_dep_tracker: pipe_depth_p must be >= 4 and exceed flush_depth_p");
   end
   if (mul_lat_p < 1 || mul_lat_p > pipe_depth_p ||
       mem_lat_p < 1 || mem_lat_p > pipe_depth_p ||
       fp_lat_p  < 1 || fp_lat_p  > pipe_depth_p) begin : g_bad_lat
      $error("bp_be_dep_tracker: latencies must satisfy 1 <= lat <= pipe_depth_p");
   end

   // A dispatch coinciding with a flush is dropped: stage 0 takes a bubble.
   always_comb begin
      dispatch_entry = '0;
      if (dispatch_v_i && !flush_i) begin
         dispatch_entry.v      = 1'b1;
         dispatch_entry.rd     = rd_addr_i;
         dispatch_entry.cls    = pipe_e'(pipe_sel_i);
         dispatch_entry.irf_w  = irf_w_v_i;
         dispatch_entry.frf_w  = frf_w_v_i;
         dispatch_entry.serial = serial_i;
      end
   end

   assign stage_n[0] = dispatch_entry;

   // Killed stages never advance, so a flushed source stage feeds a bubble
   // into its successor; sources at or beyond flush_depth_p always shift.
   for (genvar k = 1; k < pipe_depth_p; k++) begin : g_shift
      if (k - 1 >= flush_depth_p) begin : g_keep
         assign stage_n[k] = stage_r[k-1];
      end else begin : g_kill
         assign stage_n[k] = flush_i ? entry_s'('0) : stage_r[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stage_r <= '0;
      end else begin
         stage_r <= stage_n;
      end
   end

   // Status is purely a function of registered state and stage index.
   // x0 is never a hazard, so an rd of 0 suppresses the integer pending flags.
   for (genvar k = 0; k < pipe_depth_p; k++) begin : g_status
      logic iwb_ok;
      logic fwb_ok;

      assign iwb_ok = stage_r[k].v & stage_r[k].irf_w & (stage_r[k].rd != '0);
      assign fwb_ok = stage_r[k].v & stage_r[k].frf_w;

      assign v_o[k]        = stage_r[k].v;
      assign rd_addr_o[k*reg_addr_width_p +: reg_addr_width_p] = stage_r[k].rd;
      assign mem_v_o[k]    = stage_r[k].v & (stage_r[k].cls == pipe_mem);
      assign serial_v_o[k] = stage_r[k].v & stage_r[k].serial;

      assign mul_iwb_v_o[k] = iwb_ok & (stage_r[k].cls == pipe_mul) & (k + 1 < mul_lat_p);
      assign mem_iwb_v_o[k] = iwb_ok & (stage_r[k].cls == pipe_mem) & (k + 1 < mem_lat_p);
      assign fp_iwb_v_o[k]  = iwb_ok & (stage_r[k].cls == pipe_fp)  & (k + 1 < fp_lat_p);
      assign mem_fwb_v_o[k] = fwb_ok & (stage_r[k].cls == pipe_mem) & (k + 1 < mem_lat_p);
      assign fp_fwb_v_o[k]  = fwb_ok & (stage_r[k].cls == pipe_fp)  & (k + 1 < fp_lat_p);
   end

   assign instr_in_pipe_o = |v_o[2:0];
   assign mem_in_pipe_o   = |mem_v_o[2:0];
   assign serial_haz_o    = |serial_v_o[3:0];

   a_one_rf_write : assert property (@(posedge clk_i) disable iff (reset_i)
      !(irf_w_v_i && frf_w_v_i))
      else $error("bp_be_dep_tracker: irf_w_v_i and frf_w_v_i both set");

endmodule
